// File: rtl/ucode_issue_sequencer.sv
// Issue sequencer between fetch and the microcode unit: launch, eos wait, retire, halt/trap policing.
// Optional one-entry prefetch buffer enabled by defining UCODE_PREFETCH_EN.
module ucode_issue_sequencer #(
  parameter int         NUM_SEGMENTS   = 2,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [5:0] HALT_OPCODE    = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  uc_opcode,
  output logic        uc_sos,
  input  logic        uc_eos,
  output logic        busy,
  output logic        retire,
  output logic [5:0]  retire_opcode,
  output logic [15:0] retired_count,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  input  logic        clear
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]      NSEG    = 7'(NUM_SEGMENTS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_RETIRE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  logic [2:0]      state;
  logic [WD_W-1:0] wd;
  logic [5:0]      op;
  logic            armed;
  logic            take;
  logic [5:0]      new_op;
  logic            relaunch;
  logic [5:0]      relaunch_op;
  logic            wd_expire;
  logic            unused_instr;

  function automatic logic is_launchable(input logic [5:0] opc);
    return (opc != HALT_OPCODE) && ({1'b0, opc} < NSEG);
  endfunction

  assign unused_instr = ^instr[25:0];
  assign wd_expire    = (state == S_RUN) && !uc_eos && (wd == WD_LAST);

  assign uc_sos = (state == S_LAUNCH);
  assign busy   = (state != S_IDLE);
  assign retire = (state == S_RETIRE);
  assign halted = (state == S_HALT);
  assign trap   = (state == S_TRAP);

`ifdef UCODE_PREFETCH_EN
  logic       buf_vld;
  logic [5:0] buf_op;
  logic       buf_fill;

  assign instr_ready = armed && !buf_vld && (state != S_HALT) && (state != S_TRAP);
  assign take        = buf_vld || (instr_valid && instr_ready);
  assign new_op      = buf_vld ? buf_op : instr[31:26];
  assign buf_fill    = instr_valid && instr_ready &&
                       ((state == S_LAUNCH) || (state == S_RUN) || (state == S_RETIRE));
  assign relaunch    = (state == S_RETIRE) && buf_vld && is_launchable(buf_op);
  assign relaunch_op = buf_op;

  // Buffer is drained in IDLE or by a direct relaunch, and flushed on watchdog trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld <= 1'b0;
    end else if (wd_expire) begin
      buf_vld <= 1'b0;
    end else if (((state == S_IDLE) && buf_vld) || relaunch) begin
      buf_vld <= 1'b0;
    end else if (buf_fill) begin
      buf_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_fill) buf_op <= instr[31:26];
  end
`else
  assign instr_ready = armed && (state == S_IDLE);
  assign take        = instr_valid && instr_ready;
  assign new_op      = instr[31:26];
  assign relaunch    = 1'b0;
  assign relaunch_op = op;
`endif

  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && take) op <= new_op;
    else if (relaunch)             op <= relaunch_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wd            <= '0;
      armed         <= 1'b0;
      uc_opcode     <= HALT_OPCODE;
      retire_opcode <= '0;
      retired_count <= '0;
      trap_cause    <= 2'b00;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take) begin
            if (new_op == HALT_OPCODE) begin
              state     <= S_HALT;
              uc_opcode <= HALT_OPCODE;
            end else if ({1'b0, new_op} >= NSEG) begin
              state      <= S_TRAP;
              trap_cause <= 2'b01;
              uc_opcode  <= HALT_OPCODE;
            end else begin
              state     <= S_LAUNCH;
              uc_opcode <= new_op;
            end
          end
        end
        S_LAUNCH: begin
          state <= S_RUN;
          wd    <= '0;
        end
        // eos beats watchdog expiry when both land on the same edge
        S_RUN: begin
          if (uc_eos) begin
            state         <= S_RETIRE;
            retire_opcode <= op;
            retired_count <= retired_count + 16'd1;
          end else if (wd == WD_LAST) begin
            state      <= S_TRAP;
            trap_cause <= 2'b10;
            uc_opcode  <= HALT_OPCODE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RETIRE: begin
          if (relaunch) begin
            state     <= S_LAUNCH;
            uc_opcode <= relaunch_op;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
          if (clear) state <= S_IDLE;
        end
        S_TRAP: begin
          if (clear) begin
            state      <= S_IDLE;
            trap_cause <= 2'b00;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_issue_sequencer.sv
// Randomized bench for ucode_issue_sequencer (default build) against a per-transaction timing model.
module tb_ucode_issue_sequencer;

  localparam int         TO   = 64;
  localparam logic [5:0] HALT = 6'h3F;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  uc_opcode;
  logic        uc_sos;
  logic        uc_eos;
  logic        busy;
  logic        retire;
  logic [5:0]  retire_opcode;
  logic [15:0] retired_count;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        clear;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  ucode_issue_sequencer #(
    .NUM_SEGMENTS  (2),
    .TIMEOUT_CYCLES(TO),
    .HALT_OPCODE   (HALT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .uc_opcode    (uc_opcode),
    .uc_sos       (uc_sos),
    .uc_eos       (uc_eos),
    .busy         (busy),
    .retire       (retire),
    .retire_opcode(retire_opcode),
    .retired_count(retired_count),
    .halted       (halted),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .clear        (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, instr_ready, 1);
    check({tag, "_sos"}, uc_sos, 0);
    check({tag, "_retire"}, retire, 0);
    check({tag, "_trap"}, trap, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_cause"}, trap_cause, 0);
    check({tag, "_count"}, retired_count, exp_count);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_uc_opcode"}, uc_opcode, HALT);
    check({tag, "_sos"}, uc_sos, 0);
    check({tag, "_ready"}, instr_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_retire"}, retire, 0);
    check({tag, "_retire_opcode"}, retire_opcode, 0);
    check({tag, "_count"}, retired_count, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_trap"}, trap, 0);
    check({tag, "_cause"}, trap_cause, 0);
  endtask

  // Legal op: eos arrives after d idle RUN cycles; d >= TO means the watchdog fires.
  // Cycle n counts negedges after the handshake edge: LAUNCH n=1, RUN n=2..d+2, RETIRE n=d+3.
  task automatic run_legal(input logic [5:0] op, input int d, input int hold);
    bit timeout;
    int trap_n;
    int last;
    bit in_trap;
    bit busy_e;
    timeout = (d >= TO);
    trap_n  = TO + 2;
    last    = timeout ? trap_n + hold : d + 4;
    @(negedge clk);
    check("hs_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {op, 26'($urandom)};
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (n == 1) instr_valid = 1'b0;
      if (!timeout && n == d + 3) exp_count = (exp_count + 1) & 16'hFFFF;
      in_trap = timeout && (n >= trap_n);
      busy_e  = timeout ? 1'b1 : (n <= d + 3);
      check("sos", uc_sos, n == 1);
      check("busy", busy, busy_e);
      check("ready", instr_ready, !busy_e);
      check("retire", retire, !timeout && (n == d + 3));
      if (!timeout && n == d + 3) check("retire_opcode", retire_opcode, op);
      check("count", retired_count, exp_count);
      check("trap", trap, in_trap);
      check("cause", trap_cause, in_trap ? 2 : 0);
      check("halted", halted, 0);
      if (busy_e) check("uc_opcode", uc_opcode, in_trap ? HALT : op);
      uc_eos = (n == d + 2);
      clear  = in_trap ? 1'b0 : ($urandom_range(0, 3) == 0);
    end
    uc_eos = 1'b0;
    clear  = 1'b0;
    if (timeout) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_idle("wd_clear");
    end
  endtask

  // Halt or illegal op: parks in HALT/TRAP until clear, ignoring fetch and eos.
  task automatic run_stop(input logic [5:0] op, input bit is_halt, input int hold);
    @(negedge clk);
    check("stop_hs_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {op, 26'($urandom)};
    for (int n = 1; n <= hold; n++) begin
      @(negedge clk);
      check("stop_halted", halted, is_halt);
      check("stop_trap", trap, !is_halt);
      check("stop_cause", trap_cause, is_halt ? 0 : 1);
      check("stop_uc_opcode", uc_opcode, HALT);
      check("stop_sos", uc_sos, 0);
      check("stop_ready", instr_ready, 0);
      check("stop_busy", busy, 1);
      check("stop_retire", retire, 0);
      check("stop_count", retired_count, exp_count);
      uc_eos = $urandom_range(0, 1);
      if (n == hold) begin
        instr_valid = 1'b0;
        clear = 1'b1;
      end
    end
    @(negedge clk);
    clear  = 1'b0;
    uc_eos = 1'b0;
    check_idle("stop_clear");
  endtask

  task automatic reset_mid_run(input int k);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {6'h01, 26'($urandom)};
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (k + 1) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    check_reset_vals("mid_rst");
    @(negedge clk);
    check("mid_rst_retire_hold", retire, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid_rst_release");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "bench timeout");
  end

  initial begin
    int r;
    int d;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    uc_eos = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    run_legal(6'h00, 0, 0);
    run_legal(6'h01, 5, 0);
    run_legal(6'h00, TO, 3);
    run_legal(6'h01, TO - 1, 0);
    run_stop(6'h05, 1'b0, 3);
    run_stop(HALT, 1'b1, 3);
    reset_mid_run(3);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      d = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) d = TO - 1 + $urandom_range(0, 2);
      if (r < 6)       run_legal(6'($urandom_range(0, 1)), d, $urandom_range(0, 3));
      else if (r < 8)  run_stop(6'($urandom_range(2, 62)), 1'b0, $urandom_range(1, 3));
      else if (r < 9)  run_stop(HALT, 1'b1, $urandom_range(1, 3));
      else             reset_mid_run($urandom_range(0, 6));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
